// File: rtl/sb_store_buffer.sv
// sb_store_buffer
//   Store buffer between the EX/MEM stage and a single-port data memory.
//   Stores are queued in a circular FIFO and drained to memory when the port
//   is not needed by a load. Loads that match a buffered store are forwarded
//   from the youngest matching entry. Loads that miss go straight to memory.
//
// Ports
//   sb_clk, sb_rst               clock, async active-low reset
//   sb_i_st_valid/addr/data      store request
//   sb_o_st_ready                space available (registered count only)
//   sb_i_ld_valid/addr           load request
//   sb_o_ld_hit, sb_o_ld_data    forwarded hit / load result
//   sb_o_stall                   pipeline stall request
//   sb_o_empty                   no buffered stores
//   sb_o_mem_*                   data-memory port (ce, wr_en, addr, data)
//   sb_i_mem_rdata               combinational memory read data
module sb_store_buffer #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5,
  parameter int DEPTH  = 4
) (
  input  logic              sb_clk,
  input  logic              sb_rst,
  input  logic              sb_i_st_valid,
  input  logic [AWIDTH-1:0] sb_i_st_addr,
  input  logic [DWIDTH-1:0] sb_i_st_data,
  output logic              sb_o_st_ready,
  input  logic              sb_i_ld_valid,
  input  logic [AWIDTH-1:0] sb_i_ld_addr,
  output logic              sb_o_ld_hit,
  output logic [DWIDTH-1:0] sb_o_ld_data,
  output logic              sb_o_stall,
  output logic              sb_o_empty,
  output logic              sb_o_mem_ce,
  output logic              sb_o_mem_wr_en,
  output logic [AWIDTH-1:0] sb_o_mem_addr,
  output logic [DWIDTH-1:0] sb_o_mem_data,
  input  logic [DWIDTH-1:0] sb_i_mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [AWIDTH-1:0] addr_q [DEPTH];
  logic [DWIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]     head_q, tail_q;
  logic [PW:0]       count_q;

  logic              full, hit, ld_miss, load_port, drain, enq;
  logic [DWIDTH-1:0] hit_data;
  logic [PW-1:0]     idx;

  assign full          = (count_q == FULL_CNT);
  assign sb_o_st_ready = !full;
  assign sb_o_empty    = (count_q == '0);
  assign enq           = sb_i_st_valid && sb_o_st_ready;

  // Walk occupied entries oldest to youngest; later matches overwrite, so the
  // youngest matching store wins. The entry being drained this cycle is still
  // occupied and therefore still searched.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (((PW+1)'(i) < count_q) && (addr_q[idx] == sb_i_ld_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  // A missing load owns the port unless the buffer is full, in which case the
  // drain must make progress and the load stalls instead.
  assign ld_miss   = sb_i_ld_valid && !hit;
  assign load_port = ld_miss && !full;
  assign drain     = (count_q != '0) && !load_port;

  assign sb_o_stall = (sb_i_st_valid && !sb_o_st_ready) || (ld_miss && full);

  always_comb begin
    sb_o_ld_hit    = 1'b0;
    sb_o_ld_data   = '0;
    sb_o_mem_ce    = 1'b0;
    sb_o_mem_wr_en = 1'b0;
    sb_o_mem_addr  = '0;
    sb_o_mem_data  = '0;
    if (sb_i_ld_valid && hit) begin
      sb_o_ld_hit  = 1'b1;
      sb_o_ld_data = hit_data;
    end
    if (load_port) begin
      sb_o_mem_ce   = 1'b1;
      sb_o_mem_addr = sb_i_ld_addr;
      sb_o_ld_data  = sb_i_mem_rdata;
    end else if (drain) begin
      sb_o_mem_ce    = 1'b1;
      sb_o_mem_wr_en = 1'b1;
      sb_o_mem_addr  = addr_q[head_q];
      sb_o_mem_data  = data_q[head_q];
    end
  end

  always_ff @(posedge sb_clk or negedge sb_rst) begin
    if (!sb_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (enq) begin
        addr_q[tail_q] <= sb_i_st_addr;
        data_q[tail_q] <= sb_i_st_data;
        tail_q         <= tail_q + PW'(1);
      end
      if (drain) head_q <= head_q + PW'(1);
      case ({enq, drain})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_sb_store_buffer.sv
// Testbench for sb_store_buffer: directed scenarios followed by random
// traffic, all checked every cycle against a queue-based reference model
// and a behavioural data memory.
module tb_sb_store_buffer;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          st_valid, ld_valid;
  logic [AW-1:0] st_addr, ld_addr;
  logic [DW-1:0] st_data;
  logic          st_ready, ld_hit, stall, empty, mem_ce, mem_wr_en;
  logic [DW-1:0] ld_data, mem_data, mem_rdata;
  logic [AW-1:0] mem_addr;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] mem [2**AW];
  int            passes = 0;
  int            fails = 0;
  int            total = 0;
  bit            last_enq;
  bit            last_stall;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  sb_store_buffer #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH)) dut (
    .sb_clk(clk), .sb_rst(rst_n),
    .sb_i_st_valid(st_valid), .sb_i_st_addr(st_addr), .sb_i_st_data(st_data),
    .sb_o_st_ready(st_ready),
    .sb_i_ld_valid(ld_valid), .sb_i_ld_addr(ld_addr),
    .sb_o_ld_hit(ld_hit), .sb_o_ld_data(ld_data),
    .sb_o_stall(stall), .sb_o_empty(empty),
    .sb_o_mem_ce(mem_ce), .sb_o_mem_wr_en(mem_wr_en),
    .sb_o_mem_addr(mem_addr), .sb_o_mem_data(mem_data),
    .sb_i_mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_st_ready"}, st_ready, 1);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_mem_ce"}, mem_ce, 0);
    chk({tag, "_mem_wr_en"}, mem_wr_en, 0);
    chk({tag, "_ld_hit"}, ld_hit, 0);
  endtask

  // One clock cycle: inputs are already driven; check outputs at the falling
  // edge against the model, then advance the model at the rising edge.
  task automatic step(input string tag);
    bit            full, hit, load_owns, drn, enq;
    logic [DW-1:0] hd, e_ld, e_mdata;
    logic [AW-1:0] e_maddr;
    bit            e_ce, e_we, e_stall;
    @(negedge clk);
    full = (q.size() == DEPTH);
    hit  = 1'b0;
    hd   = '0;
    foreach (q[i]) if (q[i].a == ld_addr) begin hit = 1'b1; hd = q[i].d; end
    e_ld = '0; e_ce = 0; e_we = 0; e_maddr = '0; e_mdata = '0;
    load_owns = ld_valid && !hit && !full;
    if (ld_valid && hit) e_ld = hd;
    drn = (q.size() > 0) && !load_owns;
    if (load_owns) begin
      e_ce = 1; e_maddr = ld_addr; e_ld = mem[ld_addr];
    end else if (drn) begin
      e_ce = 1; e_we = 1; e_maddr = q[0].a; e_mdata = q[0].d;
    end
    enq = st_valid && !full;
    e_stall = (st_valid && full) || (ld_valid && !hit && full);
    chk({tag, "_st_ready"}, st_ready, !full);
    chk({tag, "_empty"}, empty, q.size() == 0);
    chk({tag, "_stall"}, stall, e_stall);
    chk({tag, "_ld_hit"}, ld_hit, ld_valid && hit);
    chk({tag, "_ld_data"}, ld_data, e_ld);
    chk({tag, "_mem_ce"}, mem_ce, e_ce);
    chk({tag, "_mem_wr_en"}, mem_wr_en, e_we);
    chk({tag, "_mem_addr"}, mem_addr, e_maddr);
    chk({tag, "_mem_data"}, mem_data, e_mdata);
    last_enq   = enq;
    last_stall = e_stall;
    @(posedge clk);
    if (drn) begin
      mem[q[0].a] = q[0].d;
      void'(q.pop_front());
    end
    if (enq) q.push_back('{a: st_addr, d: st_data});
    #1;
  endtask

  // Hold a store until accepted, bounded.
  task automatic store_until_accepted(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    st_valid = 1; st_addr = a; st_data = d;
    do begin
      step(tag);
      n++;
    end while (!last_enq && n < 10);
    chk({tag, "_accept_bound"}, last_enq, 1);
    st_valid = 0;
  endtask

  initial begin
    rst_n = 0; st_valid = 0; ld_valid = 0;
    st_addr = '0; st_data = '0; ld_addr = '0;
    for (int i = 0; i < 2**AW; i++) mem[i] = $urandom;
    #2;
    chk_reset_outputs("por");
    chk("por_ld_data", ld_data, 0);
    chk("por_mem_addr", mem_addr, 0);
    #10 rst_n = 1;
    @(posedge clk); #1;

    // single store drains the following cycle, then buffer is empty
    st_valid = 1; st_addr = 5'd3; st_data = 32'hAAAA5555;
    step("st3");
    st_valid = 0;
    step("drain3");
    chk("drain3_mem_at3", mem[3], 32'hAAAA5555);
    step("empty3");

    // youngest-entry forwarding with two stores to the same address
    ld_valid = 1; ld_addr = 5'd9;
    st_valid = 1; st_addr = 5'd7; st_data = 32'h11; step("fw_a");
    st_data = 32'h22; step("fw_b");
    st_valid = 0; ld_addr = 5'd7;
    chk("fw_count2", q.size(), 2);
    step("fw_hit");
    ld_valid = 0;
    step("fw_d1"); step("fw_d2");

    // continuous missing loads block drains until the buffer fills
    ld_valid = 1; ld_addr = 5'd20;
    for (int k = 0; k < 4; k++) begin
      st_valid = 1; st_addr = AW'(k); st_data = 32'hC0DE0000 + k;
      step("blk");
    end
    chk("blk_full", q.size(), DEPTH);
    store_until_accepted("blk5", 5'd4, 32'hC0DE0004);
    chk("blk5_stalled_first", last_stall, 0);
    ld_valid = 0;

    // full buffer with continuous stores: write order across pointer wrap
    for (int k = 0; k < 6; k++) store_until_accepted("wrap", AW'(10 + k), 32'hBEEF0000 + k);
    for (int k = 0; k < 6; k++) step("wrap_drain");
    chk("wrap_empty", q.size(), 0);
    chk("wrap_mem15", mem[15], 32'hBEEF0005);

    // asynchronous reset mid-cycle with three buffered stores
    ld_valid = 1; ld_addr = 5'd21;
    for (int k = 0; k < 3; k++) begin
      st_valid = 1; st_addr = AW'(24 + k); st_data = 32'hDEAD0000 + k;
      step("pre_rst");
    end
    st_valid = 0;
    #2;
    ld_valid = 0; rst_n = 0;
    #1;
    chk_reset_outputs("mid_rst");
    q.delete();
    @(posedge clk); #1;
    chk_reset_outputs("rst_held");
    rst_n = 1;
    for (int k = 0; k < 5; k++) step("post_rst");

    // random traffic
    for (int k = 0; k < 400; k++) begin
      st_valid = ($urandom_range(0, 9) < 6);
      st_addr  = AW'($urandom_range(0, 7));
      st_data  = $urandom;
      ld_valid = ($urandom_range(0, 9) < 4);
      ld_addr  = AW'($urandom_range(0, 7));
      step("rnd");
    end
    st_valid = 0; ld_valid = 0;
    for (int k = 0; k < DEPTH + 1; k++) step("rnd_flush");
    chk("final_empty", empty, 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
